// File: rtl/width_chroma_seq.sv
// Luma-dependent chroma-cluster width W(Y) with a sequential restoring divider.
// Optional: define WIDTH_CHROMA_SEQ_ROUND_EN for a round-half-up quotient.
module width_chroma_seq #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8,
    parameter int Y_MIN  = 16,
    parameter int Y_MAX  = 235,
    parameter int K_L    = 125,
    parameter int K_H    = 188,
    parameter int W_CB   = 47,
    parameter int WL_CB  = 23,
    parameter int WH_CB  = 14,
    parameter int W_CR   = 39,
    parameter int WL_CR  = 20,
    parameter int WH_CR  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_y,
    input  logic                     in_chan,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+FRAC_W-1:0] out_width,
    output logic                     out_chan,
    output logic                     busy
);

    localparam int NUM_W = 2*DATA_W + FRAC_W;
    localparam int RES_W = DATA_W + FRAC_W;
    localparam int CNT_W = $clog2(NUM_W + 1);

    localparam logic [DATA_W-1:0] P_YMIN = DATA_W'(Y_MIN);
    localparam logic [DATA_W-1:0] P_YMAX = DATA_W'(Y_MAX);
    localparam logic [DATA_W-1:0] P_KL   = DATA_W'(K_L);
    localparam logic [DATA_W-1:0] P_KH   = DATA_W'(K_H);
    localparam logic [DATA_W-1:0] D_LO   = DATA_W'(K_L - Y_MIN);
    localparam logic [DATA_W-1:0] D_HI   = DATA_W'(Y_MAX - K_H);
    localparam logic [DATA_W-1:0] CB_W   = DATA_W'(W_CB);
    localparam logic [DATA_W-1:0] CB_WL  = DATA_W'(WL_CB);
    localparam logic [DATA_W-1:0] CB_WH  = DATA_W'(WH_CB);
    localparam logic [DATA_W-1:0] CR_W   = DATA_W'(W_CR);
    localparam logic [DATA_W-1:0] CR_WL  = DATA_W'(WL_CR);
    localparam logic [DATA_W-1:0] CR_WH  = DATA_W'(WH_CR);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_W);

    if (K_L <= Y_MIN || Y_MAX <= K_H) begin : g_err_div0
        $error("width_chroma_seq: knee placement gives a zero divisor");
    end
    if (K_L >= K_H) begin : g_err_knee
        $error("width_chroma_seq: K_L must be below K_H");
    end
    if (W_CB < WL_CB || W_CB < WH_CB || W_CR < WL_CR || W_CR < WH_CR) begin : g_err_w
        $error("width_chroma_seq: centre width below band width");
    end

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_ADD, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                w_accept;
    logic [NUM_W:0]      r_num;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_div;
    logic [RES_W-1:0]    r_off;
    logic [RES_W-1:0]    r_res;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_chan;

    logic [DATA_W-1:0]   w_w, w_wl, w_wh;
    logic                w_low, w_high, w_byp;
    logic [DATA_W-1:0]   w_d, w_diff, w_den;
    logic [2*DATA_W-1:0] w_prod;
    logic [NUM_W:0]      w_num;
    logic [RES_W-1:0]    w_off, w_byp_res;
    logic [DATA_W:0]     w_trial;
    logic                w_ge;
    logic [DATA_W-1:0]   w_rem_nx;

    // Band selection and numerator setup from the live input sample
    assign w_w    = in_chan ? CR_W  : CB_W;
    assign w_wl   = in_chan ? CR_WL : CB_WL;
    assign w_wh   = in_chan ? CR_WH : CB_WH;
    assign w_low  = (in_y <= P_KL);
    assign w_high = (in_y >= P_KH);
    assign w_byp  = !w_low && !w_high;

    always_comb begin
        w_d = '0;
        if (w_low) begin
            if (in_y > P_YMIN) w_d = in_y - P_YMIN;
        end else begin
            if (in_y < P_YMAX) w_d = P_YMAX - in_y;
        end
    end

    assign w_diff    = w_low ? (w_w - w_wl) : (w_w - w_wh);
    assign w_den     = w_low ? D_LO : D_HI;
    assign w_prod    = {{DATA_W{1'b0}}, w_diff} * {{DATA_W{1'b0}}, w_d};
    assign w_off     = {(w_low ? w_wl : w_wh), {FRAC_W{1'b0}}};
    assign w_byp_res = {w_w, {FRAC_W{1'b0}}};

`ifdef WIDTH_CHROMA_SEQ_ROUND_EN
    assign w_num = {1'b0, w_prod, {FRAC_W{1'b0}}}
                 + {{(NUM_W+1-DATA_W){1'b0}}, (w_den >> 1)};
`else
    assign w_num = {1'b0, w_prod, {FRAC_W{1'b0}}};
`endif

    // One restoring step; the remainder always stays below the divisor
    assign w_trial  = {r_rem, r_num[NUM_W]};
    assign w_ge     = (w_trial >= {1'b0, r_div});
    assign w_rem_nx = w_ge ? (w_trial[DATA_W-1:0] - r_div) : w_trial[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = w_byp ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == CNT_LAST) w_state_nx = S_ADD;
            end
            S_ADD: w_state_nx = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_off  <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_chan <= 1'b0;
        end else begin
            if (w_accept) begin
                r_chan <= in_chan;
                r_num  <= w_num;
                r_rem  <= '0;
                r_div  <= w_den;
                r_off  <= w_off;
                r_cnt  <= '0;
                if (w_byp) r_res <= w_byp_res;
            end
            if (r_state == S_DIV) begin
                r_num <= {r_num[NUM_W-1:0], w_ge};
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_ADD) r_res <= r_num[RES_W-1:0] + r_off;
        end
    end

    assign out_width = r_res;
    assign out_chan  = r_chan;

endmodule

// File: tb/tb_width_chroma_seq.sv
// Self-checking bench for width_chroma_seq: directed plan steps plus random samples.
// Expected widths come from an arithmetic model of the band formulas.
module tb_width_chroma_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_y;
    logic        in_chan;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_width;
    logic        out_chan;
    logic        busy;

    int vec  = 0;
    int miss = 0;

`ifdef WIDTH_CHROMA_SEQ_ROUND_EN
    localparam int E_CR70  = 7530;
    localparam int E_CR200 = 8089;
`else
    localparam int E_CR70  = 7529;
    localparam int E_CR200 = 8088;
`endif

    always #5 clk = ~clk;

    width_chroma_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_chan   (in_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_width (out_width),
        .out_chan  (out_chan),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp)
        else begin
            miss++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // W(Y) from the band rules using plain integer arithmetic
    function automatic int model(input bit c, input int y);
        int w, wl, wh, d, n, den, off;
        w  = c ? 39 : 47;
        wl = c ? 20 : 23;
        wh = c ? 10 : 14;
        if (y > 125 && y < 188) return w * 256;
        if (y <= 125) begin
            d = (y > 16) ? y - 16 : 0;
            n = (w - wl) * d * 256;
            den = 109;
            off = wl * 256;
        end else begin
            d = (y < 235) ? 235 - y : 0;
            n = (w - wh) * d * 256;
            den = 47;
            off = wh * 256;
        end
`ifdef WIDTH_CHROMA_SEQ_ROUND_EN
        n = n + den / 2;
`endif
        return n / den + off;
    endfunction

    function automatic int lat(input int y);
        return (y > 125 && y < 188) ? 0 : 26;
    endfunction

    task automatic send(input bit c, input int y);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_chan  = c;
        in_y     = 8'(y);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_chan  = ~c;
    endtask

    // Called at accept edge + 1; counts edges until out_valid is seen
    task automatic wait_res(input string tag, input int exp_lat, input int exp_w, input bit exp_c);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_w"}, 32'(out_width), 32'(exp_w));
        chk({tag, "_c"}, 32'(out_chan), 32'(exp_c));
    endtask

    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_drain"}, 32'(out_valid), 0);
    endtask

    task automatic run(input string tag, input bit c, input int y, input int exp_w);
        send(c, y);
        wait_res(tag, lat(y), exp_w, c);
        drain(tag);
    endtask

    initial begin
        logic [15:0] hold;
        bit          seen;
        bit          rc;
        int          ry;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_y      = '0;
        in_chan   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_width", 32'(out_width), 0);
        chk("rst_chan", 32'(out_chan), 0);
        rst = 1'b0;

        run("cb150", 1'b0, 150, 12032);
        run("cb16",  1'b0, 16,  5888);
        run("cb5",   1'b0, 5,   5888);
        run("cb125", 1'b0, 125, 12032);
        run("cb188", 1'b0, 188, model(1'b0, 188));
        run("cr70",  1'b1, 70,  E_CR70);
        run("cr200", 1'b1, 200, E_CR200);
        run("cr235", 1'b1, 235, 2560);
        run("cr250", 1'b1, 250, 2560);

        // Backpressure with a second sample waiting
        out_ready = 1'b0;
        send(1'b0, 70);
        wait_res("bp1", 26, model(1'b0, 70), 1'b0);
        in_valid = 1'b1;
        in_chan  = 1'b1;
        in_y     = 8'd200;
        hold     = out_width;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_ready", 32'(in_ready), 0);
            chk("bp_stable", 32'(out_width), 32'(hold));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_busy", 32'(busy), 1);
        wait_res("bp2", 26, E_CR200, 1'b1);
        drain("bp2");

        // Reset during a division
        send(1'b0, 70);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_out", 32'(seen), 0);
        run("post_rst", 1'b0, 150, 12032);

        for (int i = 0; i < 40; i++) begin
            rc = 1'($urandom_range(0, 1));
            ry = int'($urandom_range(0, 255));
            run("rnd", rc, ry, model(rc, ry));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
